// File: rtl/zxuno_regport_if.sv
// ----------------------------------------------------------------------------
// zxuno_regport_if
// Bus bundle between the Z80 side and the ZX-UNO register port.
//   a[15:0]          Z80 address bus
//   iorq_n           Z80 IORQ, active-low
//   rd_n             Z80 RD, active-low
//   wr_n             Z80 WR, active-low
//   din[7:0]         Z80 data bus, CPU to peripherals
//   zxuno_addr[7:0]  current register index
//   zxuno_regrd      level: CPU read of the data port in progress
//   zxuno_regwr      level: CPU write of the data port in progress
//   regaddr_changed  one-cycle pulse after each write to the index port
//   dout[7:0]        readback data for the index port (FFh when idle)
//   oe_n             active-low enable for dout
// Modports: master = CPU/bus side, slave = register port.
// ----------------------------------------------------------------------------
interface zxuno_regport_if;
    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  din;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic        zxuno_regwr;
    logic        regaddr_changed;
    logic [7:0]  dout;
    logic        oe_n;

    modport master (
        output a, iorq_n, rd_n, wr_n, din,
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, dout, oe_n
    );

    modport slave (
        input  a, iorq_n, rd_n, wr_n, din,
        output zxuno_addr, zxuno_regrd, zxuno_regwr, regaddr_changed, dout, oe_n
    );
endinterface

// File: rtl/zxuno_regport.sv
// ----------------------------------------------------------------------------
// zxuno_regport
// Front end of every ZX-UNO internal register peripheral. Decodes Z80 I/O
// cycles on the index port (ADDR_PORT) and the data port (DATA_PORT), holds
// the 8-bit register index, provides read/write level qualifiers for the
// data port and a one-cycle pulse whenever the index port is written.
//
// Ports:
//   clk   system clock (Z80 bus is synchronous to it)
//   rst   asynchronous reset, active-high
//   bus   zxuno_regport_if.slave (see interface file for signal list)
//
// Optional feature macro: ZXUNO_ADDR_READBACK_EN
//   defined   -> reads of ADDR_PORT return the current index on dout, oe_n=0
//   undefined -> oe_n tied to 1, dout tied to FFh
// ----------------------------------------------------------------------------
module zxuno_regport #(
    parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
    parameter logic [15:0] DATA_PORT  = 16'hFD3B,
    parameter logic [7:0]  RESET_ADDR = 8'h00
) (
    input logic                   clk,
    input logic                   rst,
    zxuno_regport_if.slave        bus
);

    logic       w_aw;
    logic       w_dw;
    logic       w_dr;
    logic       w_capture;
    logic       r_aw_q;
    logic [7:0] r_addr;
    logic       r_changed;

    // Full 16-bit decode. A cycle with both RD and WR low counts as a write.
    assign w_aw = !bus.iorq_n && !bus.wr_n && (bus.a == ADDR_PORT);
    assign w_dw = !bus.iorq_n && !bus.wr_n && (bus.a == DATA_PORT);
    assign w_dr = !bus.iorq_n && !bus.rd_n && bus.wr_n && (bus.a == DATA_PORT);

    // Rising edge of the index-port write: one capture per bus write,
    // no matter how long the CPU holds the cycle.
    assign w_capture = w_aw && !r_aw_q;

    // r_aw_q resets to 1 so a write already active when reset releases
    // is ignored; the bus must first go idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_q    <= 1'b1;
            r_addr    <= RESET_ADDR;
            r_changed <= 1'b0;
        end else begin
            r_aw_q    <= w_aw;
            r_changed <= w_capture;
            if (w_capture) begin
                r_addr <= bus.din;
            end
        end
    end

    assign bus.zxuno_addr      = r_addr;
    assign bus.regaddr_changed = r_changed;
    assign bus.zxuno_regrd     = w_dr;
    assign bus.zxuno_regwr     = w_dw;

`ifdef ZXUNO_ADDR_READBACK_EN
    logic w_ar;

    assign w_ar     = !bus.iorq_n && !bus.rd_n && bus.wr_n && (bus.a == ADDR_PORT);
    assign bus.oe_n = !w_ar;
    assign bus.dout = w_ar ? r_addr : 8'hFF;
`else
    assign bus.oe_n = 1'b1;
    assign bus.dout = 8'hFF;
`endif

endmodule

// File: tb/tb_zxuno_regport.sv
// ----------------------------------------------------------------------------
// tb_zxuno_regport
// Directed bench for zxuno_regport. A behavioural model of the register port
// runs beside the DUT and every output is compared on each falling edge;
// hand-computed literal expectations after key bus events pin the model.
// ----------------------------------------------------------------------------
module tb_zxuno_regport;
    localparam logic [15:0] P_ADDR = 16'hFC3B;
    localparam logic [15:0] P_DATA = 16'hFD3B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    zxuno_regport_if bus ();

    zxuno_regport #(
        .ADDR_PORT  (P_ADDR),
        .DATA_PORT  (P_DATA),
        .RESET_ADDR (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index register: loaded once per CPU write transaction to the index
    // port, at the first clock of that transaction. A transaction already
    // in progress when reset releases does not count.
    logic [7:0] m_addr;
    logic       m_pulse;
    logic       m_in_idx_write;

    function automatic logic cpu_writing(input logic [15:0] port);
        return !bus.iorq_n && !bus.wr_n && (bus.a == port);
    endfunction

    function automatic logic cpu_reading(input logic [15:0] port);
        return !bus.iorq_n && !bus.rd_n && bus.wr_n && (bus.a == port);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr         = 8'h00;
            m_pulse        = 1'b0;
            m_in_idx_write = 1'b1;
        end else begin
            m_pulse = cpu_writing(P_ADDR) && !m_in_idx_write;
            if (m_pulse) m_addr = bus.din;
            m_in_idx_write = cpu_writing(P_ADDR);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        logic       e_oe_n;
        logic [7:0] e_dout;
`ifdef ZXUNO_ADDR_READBACK_EN
        e_oe_n = !cpu_reading(P_ADDR);
        e_dout = e_oe_n ? 8'hFF : m_addr;
`else
        e_oe_n = 1'b1;
        e_dout = 8'hFF;
`endif
        check("cyc_addr",  {8'h00, bus.zxuno_addr},  {8'h00, m_addr});
        check("cyc_pulse", {15'h0, bus.regaddr_changed}, {15'h0, m_pulse});
        check("cyc_regrd", {15'h0, bus.zxuno_regrd}, {15'h0, cpu_reading(P_DATA)});
        check("cyc_regwr", {15'h0, bus.zxuno_regwr}, {15'h0, cpu_writing(P_DATA)});
        check("cyc_oe_n",  {15'h0, bus.oe_n}, {15'h0, e_oe_n});
        check("cyc_dout",  {8'h00, bus.dout}, {8'h00, e_dout});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.a      = 16'h0000;
    endtask

    task automatic drive_wr(input logic [15:0] port, input logic [7:0] d);
        bus.a = port; bus.din = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.rd_n = 1'b1;
    endtask

    task automatic drive_rd(input logic [15:0] port);
        bus.a = port; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed vectors ----------------
    initial begin
        idle();
        bus.din = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_addr",  {8'h00, bus.zxuno_addr}, 16'h0000);
        check("rst_pulse", {15'h0, bus.regaddr_changed}, 16'h0000);
        check("rst_regrd", {15'h0, bus.zxuno_regrd}, 16'h0000);
        check("rst_regwr", {15'h0, bus.zxuno_regwr}, 16'h0000);
        check("rst_oe_n",  {15'h0, bus.oe_n}, 16'h0001);

        // Write FFh to index port held 4 clocks
        drive_wr(P_ADDR, 8'hFF);
        tick(1);
        check("w1_addr",  {8'h00, bus.zxuno_addr}, 16'h00FF);
        check("w1_pulse", {15'h0, bus.regaddr_changed}, 16'h0001);
        tick(1);
        check("w1_pulse_end", {15'h0, bus.regaddr_changed}, 16'h0000);
        bus.din = 8'h11;   // change during held write is ignored
        tick(2);
        check("w1_held_addr", {8'h00, bus.zxuno_addr}, 16'h00FF);
        idle();
        tick(2);
        // Same value again -> second pulse
        drive_wr(P_ADDR, 8'hFF);
        tick(1);
        check("w2_pulse", {15'h0, bus.regaddr_changed}, 16'h0001);
        check("w2_addr",  {8'h00, bus.zxuno_addr}, 16'h00FF);
        idle();
        tick(1);
        check("w2_pulse_end", {15'h0, bus.regaddr_changed}, 16'h0000);

        // Back-to-back writes with a single idle clock
        drive_wr(P_ADDR, 8'h21);
        tick(1);
        idle();
        tick(1);
        check("b2b_gap", {15'h0, bus.regaddr_changed}, 16'h0000);
        drive_wr(P_ADDR, 8'h42);
        tick(1);
        check("b2b_pulse", {15'h0, bus.regaddr_changed}, 16'h0001);
        check("b2b_addr",  {8'h00, bus.zxuno_addr}, 16'h0042);
        idle();
        tick(1);

        // Read data port for 3 clocks
        drive_rd(P_DATA);
        #1;
        check("rd_regrd", {15'h0, bus.zxuno_regrd}, 16'h0001);
        tick(3);
        check("rd_pulse", {15'h0, bus.regaddr_changed}, 16'h0000);
        idle();
        #1;
        check("rd_end", {15'h0, bus.zxuno_regrd}, 16'h0000);
        drive_rd(16'hFD3A);
        #1;
        check("rd_wrong_port", {15'h0, bus.zxuno_regrd}, 16'h0000);
        tick(2);
        idle();
        tick(1);

        // Reset mid-pulse with write still held across reset release
        drive_wr(P_ADDR, 8'h12);
        tick(1);
        check("mp_pulse", {15'h0, bus.regaddr_changed}, 16'h0001);
        rst = 1'b1;
        #1;
        check("mp_pulse_clr", {15'h0, bus.regaddr_changed}, 16'h0000);
        check("mp_addr_clr",  {8'h00, bus.zxuno_addr}, 16'h0000);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("held_addr",  {8'h00, bus.zxuno_addr}, 16'h0000);
        check("held_pulse", {15'h0, bus.regaddr_changed}, 16'h0000);
        idle();
        tick(1);
        drive_wr(P_ADDR, 8'h5A);
        tick(1);
        check("post_rst_addr",  {8'h00, bus.zxuno_addr}, 16'h005A);
        check("post_rst_pulse", {15'h0, bus.regaddr_changed}, 16'h0001);
        idle();
        tick(1);

        // RD and WR both low on data port, then data-port write
        bus.a = P_DATA; bus.din = 8'h33; bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0;
        #1;
        check("both_regwr", {15'h0, bus.zxuno_regwr}, 16'h0001);
        check("both_regrd", {15'h0, bus.zxuno_regrd}, 16'h0000);
        tick(1);
        bus.rd_n = 1'b1;
        tick(1);
        check("dw_regwr", {15'h0, bus.zxuno_regwr}, 16'h0001);
        check("dw_addr",  {8'h00, bus.zxuno_addr}, 16'h005A);
        check("dw_pulse", {15'h0, bus.regaddr_changed}, 16'h0000);
        idle();
        tick(1);

        // Index readback
        drive_wr(P_ADDR, 8'h7E);
        tick(1);
        idle();
        tick(1);
        drive_rd(P_ADDR);
        #1;
`ifdef ZXUNO_ADDR_READBACK_EN
        check("rb_oe_n", {15'h0, bus.oe_n}, 16'h0000);
        check("rb_dout", {8'h00, bus.dout}, 16'h007E);
`else
        check("rb_oe_n", {15'h0, bus.oe_n}, 16'h0001);
        check("rb_dout", {8'h00, bus.dout}, 16'h00FF);
`endif
        tick(2);
        check("rb_pulse", {15'h0, bus.regaddr_changed}, 16'h0000);
        check("rb_addr",  {8'h00, bus.zxuno_addr}, 16'h007E);
        idle();
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
